led_driver: RTL

Output-side counterpart of the button input path. It takes mode commands from the CPU/IO side through a valid/ready handshake and drives one LED pad with a clean, timed level. Supported modes are off, steady on, fixed-length pulse (minimum visible on-time) and free-running blink. It sits between the memory-mapped IO write decode and the top-level LED pin.

---
 rtl/led_driver_if.sv | 9 +
 rtl/led_driver.sv | 99 +++++++++
 2 files changed

// File: rtl/led_driver_if.sv
// Command handshake between the IO write decode and led_driver.
interface led_driver_if;
  logic       cmd_valid;
  logic [1:0] cmd_mode;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_mode, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_mode, output cmd_ready);
endinterface

// File: rtl/led_driver.sv
// LED pad driver: OFF / ON / fixed pulse / free-running blink via valid/ready commands.
// Define LED_DRIVER_ACTIVE_LOW_EN for an active-low pad (led_out idles and resets high).
//
// state   | meaning
// S_OFF   | LED dark, counter held at 0, accepts commands
// S_ON    | LED lit steadily, counter held at 0, accepts commands
// S_PULSE | LED lit for HOLD_VALUE+1 cycles, commands blocked
// S_BLINK | LED toggles every BLINK_HALF+1 cycles until next command
module led_driver #(
  parameter int COUNTER_SIZE = 8,
  parameter int HOLD_VALUE   = 255,
  parameter int BLINK_HALF   = 127
) (
  input  logic             clk,
  input  logic             reset_n,
  led_driver_if.slave      cmd,
  output logic             led_out,
  output logic             active
);

`ifdef LED_DRIVER_ACTIVE_LOW_EN
  localparam logic PAD_INV = 1'b1;
`else
  localparam logic PAD_INV = 1'b0;
`endif

  localparam logic [COUNTER_SIZE-1:0] HOLD_TC  = COUNTER_SIZE'(HOLD_VALUE);
  localparam logic [COUNTER_SIZE-1:0] BLINK_TC = COUNTER_SIZE'(BLINK_HALF);

  typedef enum logic [1:0] {S_OFF, S_ON, S_PULSE, S_BLINK} state_t;

  state_t                  state_q, state_d;
  logic [COUNTER_SIZE-1:0] cnt_q, cnt_d;
  logic                    pad_q, pad_d;
  logic                    active_q, active_d;
  logic                    lit_q, lit_d;
  logic                    accept;

  // The pad flop stores the physical level; the logical LED state is derived from it.
  assign lit_q         = pad_q ^ PAD_INV;
  assign cmd.cmd_ready = (state_q != S_PULSE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    lit_d   = lit_q;

    case (state_q)
      S_PULSE: begin
        if (cnt_q == HOLD_TC) begin
          state_d = S_OFF;
          lit_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BLINK: begin
        if (cnt_q == BLINK_TC) begin
          lit_d = ~lit_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // A new command always restarts timing from zero.
    if (accept) begin
      cnt_d = '0;
      case (cmd.cmd_mode)
        2'b00: begin state_d = S_OFF;   lit_d = 1'b0; end
        2'b01: begin state_d = S_ON;    lit_d = 1'b1; end
        2'b10: begin state_d = S_PULSE; lit_d = 1'b1; end
        default: begin state_d = S_BLINK; lit_d = 1'b1; end
      endcase
    end

    pad_d    = lit_d ^ PAD_INV;
    active_d = (state_d == S_PULSE) || (state_d == S_BLINK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      pad_q    <= PAD_INV;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pad_q    <= pad_d;
      active_q <= active_d;
    end
  end

  assign led_out = pad_q;
  assign active  = active_q;
endmodule
